// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the slave memory: burst encodings, response
// codes, FSM state constants and burst-legality helpers.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // WRAP bursts must span 2, 4, 8 or 16 transfers.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // True when the whole burst must be rejected (no array access).
    function automatic logic burst_bad(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [2:0] max_size,
        input logic       wrap_ok
    );
        logic bad;
        bad = (size > max_size);
        case (burst)
            BURST_FIXED, BURST_INCR: bad = bad;
            BURST_WRAP:              bad = bad | !wrap_ok;
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for an AXI burst given (addr, size, len, burst).
// Ports: addr/size/len/burst in, next_addr out. WRAP under AXI_SLAVE_MEM_WRAP_EN.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_addr;

    assign step      = ADDR_WIDTH'(1) << size;
    assign incr_addr = addr + step;

`ifdef AXI_SLAVE_MEM_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Window is (len+1)*step bytes; legal lengths make it a power of two.
    assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
                       - ADDR_WIDTH'(1);
    assign wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`else
    // WRAP is always rejected in this build, so its address is irrelevant.
    logic unused_len;
    assign unused_len = ^len;
    assign wrap_addr  = addr;
`endif

    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: one outstanding write and read, FIXED/INCR/WRAP, OKAY/SLVERR.
// Ports: ACLK, ARESETN (sync, active low), AW/W/B and AR/R channels.
// Option: AXI_SLAVE_MEM_WRAP_EN enables WRAP bursts of len 1/3/7/15.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int         BYTES    = DATA_WIDTH / 8;
    localparam int         LB       = $clog2(BYTES);
    localparam int         IW       = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LB);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write path ----------------
    logic [1:0]            wstate;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] wnext;
    logic [7:0]            wlen;
    logic [7:0]            wcnt;
    logic [2:0]            wsize;
    logic [1:0]            wburst;
    logic                  werr;
    logic                  w_wrap_ok;
    logic                  wbad;
    logic [ADDR_WIDTH:0]   w_off;
    logic                  w_inr;
    logic [IW-1:0]         widx;
    logic                  w_hs;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic                  mem_we;

`ifdef AXI_SLAVE_MEM_WRAP_EN
    assign w_wrap_ok = wrap_len_ok(wlen);
`else
    assign w_wrap_ok = 1'b0;
`endif

    assign wbad = burst_bad(wsize, wburst, MAX_SIZE, w_wrap_ok);

    // Extra MSB catches addresses below BASE_ADDR as a borrow.
    assign w_off = {1'b0, waddr} - {1'b0, BASE_ADDR};
    assign w_inr = !w_off[ADDR_WIDTH]
                   && ((w_off[ADDR_WIDTH-1:0] >> LB) < ADDR_WIDTH'(MEM_DEPTH));
    assign widx  = IW'(w_off[ADDR_WIDTH-1:0] >> LB);

    assign awready = ARESETN && (wstate == W_IDLE);
    assign wready  = ARESETN && (wstate == W_DATA);
    assign bvalid  = ARESETN && (wstate == W_RESP);
    assign bresp   = (bvalid && werr) ? RESP_SLVERR : RESP_OKAY;

    assign w_hs        = wready && wvalid;
    assign w_last_beat = (wcnt == wlen);
    assign w_beat_err  = wbad || !w_inr || (wlast != w_last_beat);
    assign mem_we      = w_hs && !wbad && w_inr;

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wgen (
        .addr     (waddr),
        .size     (wsize),
        .len      (wlen),
        .burst    (wburst),
        .next_addr(wnext)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate <= W_IDLE;
            waddr  <= '0;
            wlen   <= '0;
            wcnt   <= '0;
            wsize  <= '0;
            wburst <= '0;
            werr   <= 1'b0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        waddr  <= awaddr;
                        wlen   <= awlen;
                        wsize  <= awsize;
                        wburst <= awburst;
                        wcnt   <= '0;
                        werr   <= 1'b0;
                        wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        werr  <= werr | w_beat_err;
                        waddr <= wnext;
                        wcnt  <= wcnt + 8'd1;
                        // Burst length, not wlast, ends the burst.
                        if (w_last_beat) begin
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Array has no reset so contents survive ARESETN.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic [0:0]            rstate;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] rnext;
    logic [7:0]            rlen;
    logic [7:0]            rcnt;
    logic [2:0]            rsize;
    logic [1:0]            rburst;
    logic                  r_wrap_ok;
    logic                  rbad;
    logic [ADDR_WIDTH:0]   r_off;
    logic                  r_inr;
    logic [IW-1:0]         ridx;
    logic                  r_ok;

`ifdef AXI_SLAVE_MEM_WRAP_EN
    assign r_wrap_ok = wrap_len_ok(rlen);
`else
    assign r_wrap_ok = 1'b0;
`endif

    assign rbad = burst_bad(rsize, rburst, MAX_SIZE, r_wrap_ok);

    assign r_off = {1'b0, raddr} - {1'b0, BASE_ADDR};
    assign r_inr = !r_off[ADDR_WIDTH]
                   && ((r_off[ADDR_WIDTH-1:0] >> LB) < ADDR_WIDTH'(MEM_DEPTH));
    assign ridx  = IW'(r_off[ADDR_WIDTH-1:0] >> LB);

    assign arready = ARESETN && (rstate == R_IDLE);
    assign rvalid  = ARESETN && (rstate == R_DATA);
    assign r_ok    = !rbad && r_inr;
    // Combinational read: same-cycle write lands after this beat is sampled.
    assign rdata   = (rvalid && r_ok) ? mem[ridx] : '0;
    assign rresp   = (rvalid && !r_ok) ? RESP_SLVERR : RESP_OKAY;
    assign rlast   = rvalid && (rcnt == rlen);

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rgen (
        .addr     (raddr),
        .size     (rsize),
        .len      (rlen),
        .burst    (rburst),
        .next_addr(rnext)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rstate <= R_IDLE;
            raddr  <= '0;
            rlen   <= '0;
            rcnt   <= '0;
            rsize  <= '0;
            rburst <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr  <= araddr;
                        rlen   <= arlen;
                        rsize  <= arsize;
                        rburst <= arburst;
                        rcnt   <= '0;
                        rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        raddr <= rnext;
                        rcnt  <= rcnt + 8'd1;
                        if (rcnt == rlen) begin
                            rstate <= R_IDLE;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem.
// Memory window 0x1000..0x4FFF (BASE_ADDR 0x1000, 4096 words of 32 bits).
module tb_axi_slave_mem;

    localparam logic [1:0] FIX  = 2'b00;
    localparam logic [1:0] INC  = 2'b01;
    localparam logic [1:0] WRP  = 2'b10;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [64];
    logic [1:0]  rr [64];
    logic        rl [64];

    always #5 ACLK = ~ACLK;

    axi_slave_mem #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (4096),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .awaddr (awaddr),
        .awlen  (awlen),
        .awsize (awsize),
        .awburst(awburst),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wlast  (wlast),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arlen  (arlen),
        .arsize (arsize),
        .arburst(arburst),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rlast  (rlast),
        .rvalid (rvalid),
        .rready (rready)
    );

    // Full write transaction; B is held off for bstall cycles and must
    // stay at exp_b meanwhile.
    task automatic do_write(
        input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
        input logic [1:0] bt, input int last_at, input int bstall,
        input logic [1:0] exp_b, output logic [1:0] resp
    );
        int n;
        awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!awready && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) begin
            nvec++; nerr++;
            $display("FAIL aw_timeout: awready got 0, want 1");
        end
        @(posedge ACLK); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
            wlast = (last_at < 0) ? (i == int'(len)) : (i == last_at);
            n = 0;
            @(negedge ACLK);
            while (!wready && n < 50) begin n++; @(negedge ACLK); end
            if (n >= 50) begin
                nvec++; nerr++;
                $display("FAIL w_timeout: wready got 0, want 1 (beat %0d)", i);
            end
            @(posedge ACLK); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!bvalid && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) begin
            nvec++; nerr++;
            $display("FAIL b_timeout: bvalid got 0, want 1");
        end
        resp = bresp;
        for (int c = 0; c < bstall; c++) begin
            nvec++;
            if (bvalid !== 1'b1 || bresp !== exp_b) begin
                nerr++;
                $display("FAIL b_hold: bvalid/bresp got %b/%b, want 1/%b",
                         bvalid, bresp, exp_b);
            end
            @(negedge ACLK);
        end
        bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
    endtask

    // Full read transaction with rready held high; beats land in rd/rr/rl.
    task automatic do_read(
        input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
        input logic [1:0] bt, output int nb, output int ncyc
    );
        int  n;
        bit  done;
        araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!arready && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) begin
            nvec++; nerr++;
            $display("FAIL ar_timeout: arready got 0, want 1");
        end
        @(posedge ACLK); #1;
        arvalid = 1'b0; rready = 1'b1;
        nb = 0; ncyc = 0; done = 1'b0;
        while (!done && ncyc < 100) begin
            @(negedge ACLK);
            ncyc++;
            if (rvalid) begin
                rd[nb] = rdata; rr[nb] = rresp; rl[nb] = rlast;
                if (rlast || nb == 63) done = 1'b1;
                nb++;
            end
            @(posedge ACLK); #1;
        end
        rready = 1'b0;
        if (!done) begin
            nvec++; nerr++;
            $display("FAIL r_timeout: rlast got 0, want 1");
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        nvec++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b, want 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        nvec++;
        if ({awready, arready} !== 2'b11) begin
            nerr++;
            $display("FAIL reset_ready: got %b, want 11", {awready, arready});
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_single();
        logic [1:0] b;
        int nb, nc;
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h1000, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        nvec++;
        if (b !== OKAY) begin
            nerr++; $display("FAIL single_bresp: got %b, want %b", b, OKAY);
        end
        do_read(32'h1000, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (nb !== 1 || rd[0] !== 32'hDEAD_BEEF || rr[0] !== OKAY || rl[0] !== 1'b1) begin
            nerr++;
            $display("FAIL single_read: got n=%0d d=%h r=%b l=%b, want 1 deadbeef 00 1",
                     nb, rd[0], rr[0], rl[0]);
        end
    endtask

    task automatic test_incr();
        logic [1:0] b;
        int nb, nc;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h3000, 8'd3, 3'd2, INC, -1, 0, OKAY, b);
        nvec++;
        if (b !== OKAY) begin
            nerr++; $display("FAIL incr_bresp: got %b, want %b", b, OKAY);
        end
        do_read(32'h300C, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rd[0] !== 32'd4) begin
            nerr++; $display("FAIL incr_word3: got %h, want 4", rd[0]);
        end
        do_read(32'h3000, 8'd3, 3'd2, INC, nb, nc);
        nvec++;
        if (nb !== 4 || nc !== 4) begin
            nerr++;
            $display("FAIL incr_beats: got %0d beats in %0d cycles, want 4 in 4", nb, nc);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3) || rr[i] !== OKAY) begin
                nerr++;
                $display("FAIL incr_beat%0d: got d=%h l=%b r=%b, want %h %b 00",
                         i, rd[i], rl[i], rr[i], i + 1, i == 3);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0]  b;
        int          nb, nc;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h2000, 8'd3, 3'd2, INC, -1, 0, OKAY, b);
`ifdef AXI_SLAVE_MEM_WRAP_EN
        exp_d[0] = 32'hA2; exp_d[1] = 32'hA3; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
        exp_r = OKAY;
`else
        exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
        exp_r = SERR;
`endif
        do_read(32'h2008, 8'd3, 3'd2, WRP, nb, nc);
        nvec++;
        if (nb !== 4) begin
            nerr++; $display("FAIL wrap_beats: got %0d, want 4", nb);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rd[i] !== exp_d[i] || rr[i] !== exp_r) begin
                nerr++;
                $display("FAIL wrap_beat%0d: got %h/%b, want %h/%b",
                         i, rd[i], rr[i], exp_d[i], exp_r);
            end
        end
        for (int i = 0; i < 4; i++) wd[i] = 32'hEE0 + 32'(i);
        do_write(32'h2000, 8'd3, 3'd2, WRP, -1, 0, OKAY, b);
        do_read(32'h2000, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
`ifdef AXI_SLAVE_MEM_WRAP_EN
        if (b !== OKAY || rd[0] !== 32'hEE0) begin
            nerr++; $display("FAIL wrap_write: got %b/%h, want 00/ee0", b, rd[0]);
        end
`else
        if (b !== SERR || rd[0] !== 32'hA0) begin
            nerr++; $display("FAIL wrap_write: got %b/%h, want 10/a0", b, rd[0]);
        end
`endif
    endtask

    task automatic test_range();
        logic [1:0] b;
        int nb, nc;
        wd[0] = 32'h5555_5555; ws[0] = 4'hF;
        do_write(32'h5000, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        nvec++;
        if (b !== SERR) begin
            nerr++; $display("FAIL oor_bresp: got %b, want %b", b, SERR);
        end
        do_read(32'h1000, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rd[0] !== 32'hDEAD_BEEF) begin
            nerr++; $display("FAIL oor_alias: got %h, want deadbeef", rd[0]);
        end
        do_read(32'h0FFC, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rr[0] !== SERR || rd[0] !== 32'h0) begin
            nerr++; $display("FAIL below_base: got %b/%h, want 10/0", rr[0], rd[0]);
        end
        wd[0] = 32'h4F4F_4F4F;
        do_write(32'h4FFC, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        do_read(32'h4FFC, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (b !== OKAY || rr[0] !== OKAY || rd[0] !== 32'h4F4F_4F4F) begin
            nerr++;
            $display("FAIL top_word: got %b/%b/%h, want 00/00/4f4f4f4f", b, rr[0], rd[0]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] b;
        int nb, nc;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(32'h1100, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        wd[0] = 32'h1234_5678; ws[0] = 4'b0011;
        do_write(32'h1100, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        do_read(32'h1100, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rd[0] !== 32'hFFFF_5678) begin
            nerr++; $display("FAIL strobe: got %h, want ffff5678", rd[0]);
        end
    endtask

    task automatic test_size_burst_err();
        logic [1:0] b;
        int nb, nc;
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(32'h1100, 8'd0, 3'd3, INC, -1, 0, OKAY, b);
        do_read(32'h1100, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (b !== SERR || rd[0] !== 32'hFFFF_5678) begin
            nerr++;
            $display("FAIL size_err: got %b/%h, want 10/ffff5678", b, rd[0]);
        end
        do_read(32'h1000, 8'd1, 3'd2, 2'b11, nb, nc);
        nvec++;
        if (nb !== 2 || rr[0] !== SERR || rr[1] !== SERR || rd[0] !== 32'h0) begin
            nerr++;
            $display("FAIL burst_err: got n=%0d %b/%b d=%h, want 2 10/10 0",
                     nb, rr[0], rr[1], rd[0]);
        end
        do_read(32'h1000, 8'd1, 3'd2, FIX, nb, nc);
        nvec++;
        if (nb !== 2 || rd[1] !== 32'hDEAD_BEEF || rr[1] !== OKAY) begin
            nerr++;
            $display("FAIL fixed_read: got n=%0d %h/%b, want 2 deadbeef/00",
                     nb, rd[1], rr[1]);
        end
    endtask

    task automatic test_wlast();
        logic [1:0] b;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h61 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h1200, 8'd3, 3'd2, INC, 1, 5, SERR, b);
        nvec++;
        if (b !== SERR) begin
            nerr++; $display("FAIL wlast_bresp: got %b, want %b", b, SERR);
        end
    endtask

    // Same-word read and write in one cycle, plus handshake latencies.
    task automatic test_back_to_back();
        logic [1:0] b;
        int nb, nc;
        wd[0] = 32'hAAAA_0001; ws[0] = 4'hF;
        do_write(32'h1500, 8'd0, 3'd2, INC, -1, 0, OKAY, b);
        awaddr = 32'h1500; awlen = 8'd0; awsize = 3'd2; awburst = INC; awvalid = 1'b1;
        araddr = 32'h1500; arlen = 8'd0; arsize = 3'd2; arburst = INC; arvalid = 1'b1;
        @(posedge ACLK); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        wdata = 32'hBBBB_0002; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        @(negedge ACLK);
        nvec++;
        if ({wready, rvalid, awready, arready} !== 4'b1100) begin
            nerr++;
            $display("FAIL hs_latency: wready/rvalid/awready/arready got %b, want 1100",
                     {wready, rvalid, awready, arready});
        end
        nvec++;
        if (rdata !== 32'hAAAA_0001) begin
            nerr++; $display("FAIL rw_same_word: got %h, want aaaa0001", rdata);
        end
        @(posedge ACLK); #1;
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        @(negedge ACLK);
        nvec++;
        if (bvalid !== 1'b1 || bresp !== OKAY || rvalid !== 1'b0) begin
            nerr++;
            $display("FAIL b_latency: bvalid/bresp/rvalid got %b/%b/%b, want 1/00/0",
                     bvalid, bresp, rvalid);
        end
        bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
        do_read(32'h1500, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rd[0] !== 32'hBBBB_0002) begin
            nerr++; $display("FAIL rw_after: got %h, want bbbb0002", rd[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] b;
        int nb, nc;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
        do_write(32'h1400, 8'd3, 3'd2, INC, -1, 0, OKAY, b);
        awaddr = 32'h1400; awlen = 8'd3; awsize = 3'd2; awburst = INC; awvalid = 1'b1;
        @(posedge ACLK); #1;
        awvalid = 1'b0;
        wstrb = 4'hF; wvalid = 1'b1; wlast = 1'b0;
        wdata = 32'h11;
        @(posedge ACLK); #1;
        wdata = 32'h22;
        @(posedge ACLK); #1;
        wdata = 32'h33;
        ARESETN = 1'b0;
        @(negedge ACLK);
        nvec++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            nerr++;
            $display("FAIL midreset_outputs: got %b, want 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        repeat (2) @(posedge ACLK);
        #1;
        wvalid = 1'b0;
        ARESETN = 1'b1;
        @(negedge ACLK);
        nvec++;
        if ({awready, wready, arready, rvalid} !== 4'b1010) begin
            nerr++;
            $display("FAIL midreset_idle: got %b, want 1010",
                     {awready, wready, arready, rvalid});
        end
        @(posedge ACLK); #1;
        do_read(32'h1400, 8'd2, 3'd2, INC, nb, nc);
        nvec++;
        if (nb !== 3 || rd[0] !== 32'h11 || rd[1] !== 32'h22 || rd[2] !== 32'h0) begin
            nerr++;
            $display("FAIL midreset_mem: got n=%0d %h %h %h, want 3 11 22 0",
                     nb, rd[0], rd[1], rd[2]);
        end
        do_read(32'h1000, 8'd0, 3'd2, INC, nb, nc);
        nvec++;
        if (rd[0] !== 32'hDEAD_BEEF || rr[0] !== OKAY || rl[0] !== 1'b1) begin
            nerr++;
            $display("FAIL midreset_read: got %h/%b/%b, want deadbeef/00/1",
                     rd[0], rr[0], rl[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_range();
        test_strobe();
        test_size_burst_err();
        test_wlast();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
